ctrl_pipe_hazard: RTL
=====================

Name: ctrl_pipe_hazard

Overview:
Consumes the decoded control bundle from the single-cycle control decoder in ID and carries it through the ID/EX, EX/MEM and MEM/WB control registers of the pipelined MIPS-Lite core. Detects load-use hazards, stalls the front end and inserts bubbles. Flushes on taken branch/jump resolved in EX. Generates EX-stage forwarding selects.

Parameters:
REG_AW, 5, register-specifier width
LINK_REG, 31, destination register for JAL

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jump  in  1 each  decoder outputs for the ID instruction
id_ALUOp  in  2  decoder ALUOp
id_link  in  1  ID instruction is JAL
id_rs, id_rt, id_rd  in  5 each  ID register specifiers
ex_redirect  in  1  EX resolved a taken branch (Branch & zero) or a jump
pc_write  out  1  PC load enable (0 = hold)
ifid_write  out  1  IF/ID load enable (0 = hold)
ifid_flush  out  1  clear IF/ID to NOP
ex_ALUSrc, ex_Branch, ex_Jump  out  1 each  ID/EX control
ex_ALUOp  out  2  ID/EX ALUOp
ex_rs, ex_rt  out  5 each  EX source specifiers
ex_wreg  out  5  EX destination register after RegDst/link select
mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg  out  1 each  EX/MEM control
mem_wreg  out  5  EX/MEM destination
wb_RegWrite, wb_MemtoReg  out  1 each  MEM/WB control
wb_wreg  out  5  MEM/WB destination
fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB

Behaviour:
- Reset (async, rst=1): every registered control bit and register field is 0; stall and flush inactive, so pc_write=1, ifid_write=1, ifid_flush=0, fwd_a=fwd_b=00. Reset mid-operation discards all in-flight control immediately.
- Pipeline advances every posedge: ID->EX, EX->MEM, MEM->WB. One cycle per stage; no back-pressure beyond load-use.
- Destination select on ID->EX load: id_link ? LINK_REG : (id_RegDst ? id_rd : id_rt). When id_RegWrite=0, load ex_wreg=0.
- Load-use hazard (combinational): ex MemRead=1 AND ex_wreg!=0 AND (ex_wreg==id_rs OR ex_wreg==id_rt). Then pc_write=0, ifid_write=0, and ID/EX loads a bubble (all control 0, wreg 0). Exactly one stall cycle per hazard.
- Flush: ex_redirect=1 -> ifid_flush=1 and ID/EX loads a bubble. pc_write=1, ifid_write=1.
- Simultaneous hazard and redirect: redirect wins. No stall, bubble in ID/EX, IF/ID flushed.
- Bubble loads force all control to 0 regardless of decoder inputs, including x from unimplemented opcodes. Non-bubble loads copy inputs verbatim.
- Forwarding for fwd_a (rs); fwd_b is identical using ex_rt:
  - 10 if mem_RegWrite and mem_wreg!=0 and mem_wreg==ex_rs;
  - else 01 if wb_RegWrite and wb_wreg!=0 and wb_wreg==ex_rs;
  - else 00. EX/MEM has priority over MEM/WB.
- $0 never causes a hazard or a forward.
- JAL write-back uses wreg=LINK_REG. Selecting PC+4 as the data source is outside this block.

Decomposition:
- Shared package holds opcode constants (R_FORMAT=0, J=2, JAL=3, BEQ=4, ADDIU=9, LW=35, SW=43), ALUOp encodings (00 add, 01 sub, 10 funct) and fwd select encodings. The decoder uses the same package.
- One sub-module, hazard_fwd_unit: purely combinational stall and forwarding logic. The top module holds the three control registers.

Test Plan:
- Reset: assert rst mid-stream with RegWrite bubbles in flight -> all ex_/mem_/wb_ outputs 0 the same cycle; pc_write=1, fwd_a=fwd_b=00.
- Load-use: LW rt=8, then ADD rs=8 -> one cycle with pc_write=0 and ifid_write=0, bubble in EX; next cycle fwd_a=01 for the ADD.
- EX forwarding: ADD rd=5, then SUB rs=5 rt=5 -> fwd_a=fwd_b=10. Same sequence with rd=0 -> 00.
- Priority: ADD rd=6, ADD rd=6, ADD rs=6 -> fwd_a=10, not 01.
- Redirect: BEQ with ex_redirect=1 -> ifid_flush=1 and next ex_* all 0. With a load-use hazard in the same cycle -> pc_write=1 and flush taken.
- JAL and illegal opcode: id_link=1, RegWrite=1 -> ex_wreg=31, then mem_wreg=31, then wb_wreg=31. Decoder x outputs on the cycle ex_redirect=1 -> ex_* outputs 0, not x.

Source files
------------

// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared definitions for the MIPS-Lite control path: opcodes, ALUOp codes,
// forwarding-select codes and the control bundle carried from ID into EX.
package ctrl_pipe_hazard_pkg;

  // Primary opcodes recognised by the single-cycle decoder.
  typedef enum logic [5:0] {
    OP_R_FORMAT = 6'd0,
    OP_J        = 6'd2,
    OP_JAL      = 6'd3,
    OP_BEQ      = 6'd4,
    OP_ADDIU    = 6'd9,
    OP_LW       = 6'd35,
    OP_SW       = 6'd43
  } opcode_e;

  // ALUOp: how the ALU control should interpret the instruction.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // EX operand source select. EX/MEM and MEM/WB use one-hot-ish codes so a
  // stray 11 is visibly illegal.
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EXMEM   = 2'b10,
    FWD_MEMWB   = 2'b01
  } fwd_sel_e;

  // Control bits latched into ID/EX. ALUOp is kept as raw bits so that the
  // bundle is copied verbatim, including encodings the ALU does not use.
  typedef struct packed {
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
  } ex_ctrl_t;

  // An all-zero control bundle: the bubble inserted on stall or flush.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage : ctrl_pipe_hazard_pkg

// File: rtl/ctrl_pipe_hazard_hazard_fwd_unit.sv
// Combinational load-use stall, branch/jump flush and EX forwarding selects.
module hazard_fwd_unit
  import ctrl_pipe_hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_redirect,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_wreg,
  output logic              bubble,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic load_use;
  logic stall;

  // Pick the youngest in-flight producer of src; $0 is never forwarded.
  function automatic fwd_sel_e pick_src(
    input logic [REG_AW-1:0] src,
    input logic              m_rw,
    input logic [REG_AW-1:0] m_wreg,
    input logic              w_rw,
    input logic [REG_AW-1:0] w_wreg
  );
    if (m_rw && (m_wreg != '0) && (m_wreg == src)) begin
      return FWD_EXMEM;
    end else if (w_rw && (w_wreg != '0) && (w_wreg == src)) begin
      return FWD_MEMWB;
    end else begin
      return FWD_REGFILE;
    end
  endfunction

  // Stall/flush arbitration: a redirect squashes the ID instruction anyway,
  // so it overrides a load-use stall instead of holding a dead instruction.
  always_comb begin
    load_use   = ex_memread && (ex_wreg != '0) &&
                 ((ex_wreg == id_rs) || (ex_wreg == id_rt));
    stall      = 1'b0;
    bubble     = 1'b0;
    ifid_flush = 1'b0;
    if (ex_redirect) begin
      bubble     = 1'b1;
      ifid_flush = 1'b1;
    end else if (load_use) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
    pc_write   = ~stall;
    ifid_write = ~stall;
  end

  // Operand select for the instruction currently in EX.
  always_comb begin
    fwd_a = pick_src(ex_rs, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
    fwd_b = pick_src(ex_rt, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
  end

endmodule : hazard_fwd_unit

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline of the MIPS-Lite core: ID/EX, EX/MEM and MEM/WB control
// registers with load-use stall, redirect flush and EX forwarding selects.
module ctrl_pipe_hazard
  import ctrl_pipe_hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_RegDst,
  input  logic              id_ALUSrc,
  input  logic              id_MemtoReg,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic              id_Jump,
  input  logic [1:0]        id_ALUOp,
  input  logic              id_link,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              ex_ALUSrc,
  output logic              ex_Branch,
  output logic              ex_Jump,
  output logic [1:0]        ex_ALUOp,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic              mem_RegWrite,
  output logic              mem_MemtoReg,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [REG_AW-1:0] wb_wreg,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);

  ex_ctrl_t          id_ctrl;
  ex_ctrl_t          ex_ctrl;
  logic [REG_AW-1:0] id_wreg;
  logic              bubble;

  // Gather decoder outputs into one bundle and resolve the destination.
  // A non-writing instruction carries wreg=0 so it can never match.
  always_comb begin
    id_ctrl.alusrc   = id_ALUSrc;
    id_ctrl.branch   = id_Branch;
    id_ctrl.jump     = id_Jump;
    id_ctrl.aluop    = id_ALUOp;
    id_ctrl.memread  = id_MemRead;
    id_ctrl.memwrite = id_MemWrite;
    id_ctrl.regwrite = id_RegWrite;
    id_ctrl.memtoreg = id_MemtoReg;
    id_wreg          = '0;
    if (id_RegWrite) begin
      if (id_link) begin
        id_wreg = LINK_ADDR;
      end else if (id_RegDst) begin
        id_wreg = id_rd;
      end else begin
        id_wreg = id_rt;
      end
    end
  end

  hazard_fwd_unit #(
    .REG_AW (REG_AW)
  ) u_hazard_fwd (
    .ex_memread   (ex_ctrl.memread),
    .ex_wreg      (ex_wreg),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_redirect  (ex_redirect),
    .mem_regwrite (mem_RegWrite),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_RegWrite),
    .wb_wreg      (wb_wreg),
    .bubble       (bubble),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  // ID/EX register: a bubble clears the whole entry so unknown decoder
  // outputs from a squashed instruction never reach EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl <= EX_CTRL_BUBBLE;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_wreg <= '0;
    end else if (bubble) begin
      ex_ctrl <= EX_CTRL_BUBBLE;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_wreg <= '0;
    end else begin
      ex_ctrl <= id_ctrl;
      ex_rs   <= id_rs;
      ex_rt   <= id_rt;
      ex_wreg <= id_wreg;
    end
  end

  assign ex_ALUSrc = ex_ctrl.alusrc;
  assign ex_Branch = ex_ctrl.branch;
  assign ex_Jump   = ex_ctrl.jump;
  assign ex_ALUOp  = ex_ctrl.aluop;

  // EX/MEM register: memory and write-back controls move on every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
      mem_RegWrite <= 1'b0;
      mem_MemtoReg <= 1'b0;
      mem_wreg     <= '0;
    end else begin
      mem_MemRead  <= ex_ctrl.memread;
      mem_MemWrite <= ex_ctrl.memwrite;
      mem_RegWrite <= ex_ctrl.regwrite;
      mem_MemtoReg <= ex_ctrl.memtoreg;
      mem_wreg     <= ex_wreg;
    end
  end

  // MEM/WB register: only the write-back controls survive past MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_RegWrite <= 1'b0;
      wb_MemtoReg <= 1'b0;
      wb_wreg     <= '0;
    end else begin
      wb_RegWrite <= mem_RegWrite;
      wb_MemtoReg <= mem_MemtoReg;
      wb_wreg     <= mem_wreg;
    end
  end

endmodule : ctrl_pipe_hazard
